// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
//
// Purpose:
//   Decode -> execute pipeline stage that sits beside the register file.
//   It drives both register-file read addresses straight from decode and
//   captures the selected operands in a valid/ready output register.
//
//   A per-register scoreboard (busy) tracks writers that have been issued
//   but have not yet written back. Decode stalls on these hazards:
//     - RAW: a source operand is still being produced.
//     - WAW: the destination already has a writer in flight.
//
//   Register-file writes land one clock after the writeback strobe. Because
//   of that, a writeback in the same cycle as the read can be forwarded
//   directly from wb_data.
//
// Configuration:
//   OPFETCH_WB_BYPASS_EN
//     Defined:   same-cycle writeback data is forwarded into the operands.
//     Undefined: no forwarding. A dependent instruction waits one more
//                cycle and then reads the updated register file. Operand
//                values are the same either way; only timing differs.
//
// Parameters:
//   XLEN      datapath width, must equal the register-file data width
//   NUM_REGS  number of architectural registers; x0 always reads as zero
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   id_valid / id_ready            decode handshake
//   id_rs1, id_rs2, id_rd          decode register fields
//   id_rd_we, id_pc                decode write enable and PC
//   rf_src_addr_1/2                register-file read addresses (= id_rs1/2)
//   rf_src_data_1/2                register-file read data (combinational)
//   wb_valid, wb_rd, wb_data       writeback port (wb_valid is also the RF write enable)
//   flush                          kill the instruction held in the output register
//   ex_valid / ex_ready            execute handshake
//   ex_rs1_data, ex_rs2_data       captured operands
//   ex_rd, ex_rd_we, ex_pc         captured destination, write enable and PC
// ---------------------------------------------------------------------------
module operand_fetch_stage #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_we,
  input  logic [XLEN-1:0] id_pc,

  output logic [AW-1:0]   rf_src_addr_1,
  output logic [AW-1:0]   rf_src_addr_2,
  input  logic [XLEN-1:0] rf_src_data_1,
  input  logic [XLEN-1:0] rf_src_data_2,

  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,

  input  logic            flush,

  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_rd_we,
  output logic [XLEN-1:0] ex_pc
);

  // Scoreboard state: busy[r] is set while a writer of r is in flight.
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Hazard and handshake terms.
  logic            fwd1;
  logic            fwd2;
  logic            raw1;
  logic            raw2;
  logic            waw;
  logic            wb_hits_rd;
  logic            stage_free;
  logic            accept;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  // The register file is read directly from the decode fields, so the read
  // data arrives in the same cycle as the instruction.
  assign rf_src_addr_1 = id_rs1;
  assign rf_src_addr_2 = id_rs2;

  // Forwarding matches a writeback in the current cycle to a source
  // register. x0 is never forwarded, because it is hardwired to zero.
  // Without the bypass, a matching writeback cannot satisfy the read this
  // cycle. The RAW check below then stalls until the write has landed.
`ifdef OPFETCH_WB_BYPASS_EN
  assign fwd1 = wb_valid && (wb_rd == id_rs1) && (id_rs1 != '0);
  assign fwd2 = wb_valid && (wb_rd == id_rs2) && (id_rs2 != '0);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // RAW: a source is still being produced and cannot be forwarded.
  assign raw1 = (id_rs1 != '0) && busy[id_rs1] && !fwd1;
  assign raw2 = (id_rs2 != '0) && busy[id_rs2] && !fwd2;

  // WAW: allow at most one writer in flight per register. A writeback to the
  // same register in this cycle frees the slot. This does not depend on the
  // bypass, because no data moves.
  assign wb_hits_rd = wb_valid && (wb_rd == id_rd);
  assign waw        = id_rd_we && (id_rd != '0) && busy[id_rd] && !wb_hits_rd;

  // The output register can take a new instruction when it is empty or is
  // being drained this cycle. id_ready deliberately ignores id_valid.
  assign stage_free = !ex_valid || ex_ready;
  assign id_ready   = !flush && !raw1 && !raw2 && !waw && stage_free;
  assign accept     = id_valid && id_ready;

  // Operand select: x0 reads as zero, then forwarded writeback data, then
  // the register-file read data.
  assign op1 = (id_rs1 == '0) ? '0 : (fwd1 ? wb_data : rf_src_data_1);
  assign op2 = (id_rs2 == '0) ? '0 : (fwd2 ? wb_data : rf_src_data_2);

  // Next-state computation for the scoreboard.
  // For each register, the updates are applied in this order:
  //   1. A writeback clears the bit.
  //   2. Flushing a writer in the output register clears the bit.
  //   3. Accepting a new writer sets the bit.
  // Because the set is applied last, it wins over a clear in the same cycle.
  // That matters when a WAW stall is released by the writeback it waited
  // for. x0 is never tracked.
  always_comb begin
    busy_next    = busy;
    busy_next[0] = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (wb_valid && (wb_rd == AW'(r))) begin
        busy_next[r] = 1'b0;
      end
      if (flush && ex_valid && ex_rd_we && (ex_rd == AW'(r))) begin
        busy_next[r] = 1'b0;
      end
      if (accept && id_rd_we && (id_rd == AW'(r))) begin
        busy_next[r] = 1'b1;
      end
    end
  end

  // Scoreboard register. It clears immediately on reset, with no clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Output register.
  //   - A flush empties it.
  //   - An accepted instruction loads it.
  //   - A consume with nothing new empties it.
  // The payload loads only on accept, so while execute is stalled every ex_*
  // output holds stable. accept already excludes flush, so flush never
  // competes with a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd       <= '0;
      ex_rd_we    <= 1'b0;
      ex_pc       <= '0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid <= 1'b1;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end

      if (accept) begin
        ex_rs1_data <= op1;
        ex_rs2_data <= op2;
        ex_rd       <= id_rd;
        ex_rd_we    <= id_rd_we;
        ex_pc       <= id_pc;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch_stage
//
// Directed testbench for operand_fetch_stage.
// It models the register file:
//   - Combinational read.
//   - Write one clock after wb_valid.
//   - Reset to a known pattern.
// Each scenario task drives stimulus and checks results inline. Timing
// follows the build: with OPFETCH_WB_BYPASS_EN undefined, the dependent
// instruction is accepted one cycle later.
// ---------------------------------------------------------------------------
module tb_operand_fetch_stage;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int AW       = 5;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic            id_ready;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic [AW-1:0]   id_rd;
  logic            id_rd_we;
  logic [XLEN-1:0] id_pc;
  logic [AW-1:0]   rf_src_addr_1;
  logic [AW-1:0]   rf_src_addr_2;
  logic [XLEN-1:0] rf_src_data_1;
  logic [XLEN-1:0] rf_src_data_2;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [AW-1:0]   ex_rd;
  logic            ex_rd_we;
  logic [XLEN-1:0] ex_pc;

  logic [XLEN-1:0] rf [NUM_REGS];

  int checks;
  int errors;

  operand_fetch_stage #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we), .id_pc(id_pc),
    .rf_src_addr_1(rf_src_addr_1), .rf_src_addr_2(rf_src_addr_2),
    .rf_src_data_1(rf_src_data_1), .rf_src_data_2(rf_src_data_2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_pc(ex_pc)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model.
  //   - Resets to 0x1000_0000 + index.
  //   - Writes land at the edge after wb_valid.
  //   - x0 is stored like any other entry, so the stage must mask it itself.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= 32'h1000_0000 + i;
    end else if (wb_valid) begin
      rf[wb_rd] <= wb_data;
    end
  end

  assign rf_src_data_1 = rf[rf_src_addr_1];
  assign rf_src_data_2 = rf[rf_src_addr_2];

  // Advance one clock and land just after the edge, where the registered
  // outputs are stable and new inputs can be driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return every input to the idle state.
  task automatic idle();
    id_valid = 1'b0;
    id_rs1   = '0;
    id_rs2   = '0;
    id_rd    = '0;
    id_rd_we = 1'b0;
    id_pc    = '0;
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    flush    = 1'b0;
    ex_ready = 1'b1;
  endtask

  // Power-on reset: outputs clear and the stage is ready.
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_valid got %0h want 0", ex_valid); end
    checks++; if (ex_rd_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_rd_we got %0h want 0", ex_rd_we); end
    checks++; if (ex_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_ex_pc got %h want 0", ex_pc); end
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("[TB] FAIL reset_busy got %h want 0", dut.busy); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_id_ready got %0h want 1", id_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Asserting reset mid-operation clears state at once, without a clock edge.
  task automatic test_reset_midop();
    id_valid = 1'b1; id_rd = 5'd5; id_rd_we = 1'b1; id_pc = 32'h100; ex_ready = 1'b0;
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL midop_pre_ex_valid got %0h want 1", ex_valid); end
    checks++; if (dut.busy[5] !== 1'b1) begin errors++; $display("[TB] FAIL midop_pre_busy5 got %0h want 1", dut.busy[5]); end
    id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL midop_ex_valid got %0h want 0", ex_valid); end
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("[TB] FAIL midop_busy got %h want 0", dut.busy); end
    checks++; if (ex_pc !== 32'h0) begin errors++; $display("[TB] FAIL midop_ex_pc got %h want 0", ex_pc); end
    #3 rst_n = 1'b1;
    idle();
    step();
  endtask

  // RAW hazard on rd=5, released by a writeback of 0xDEADBEEF.
  task automatic test_raw_bypass();
    id_valid = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rd = 5'd5; id_rd_we = 1'b1; id_pc = 32'h200;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_first_ready got %0h want 1", id_ready); end
    step();
    checks++; if (dut.busy[5] !== 1'b1) begin errors++; $display("[TB] FAIL raw_busy5_set got %0h want 1", dut.busy[5]); end
    checks++; if (ex_rd !== 5'd5) begin errors++; $display("[TB] FAIL raw_first_ex_rd got %0d want 5", ex_rd); end
    id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd6; id_rd_we = 1'b1; id_pc = 32'h204;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_stall1 got %0h want 0", id_ready); end
    step();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_stall2 got %0h want 0", id_ready); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL raw_bubble_ex_valid got %0h want 0", ex_valid); end
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
`ifdef OPFETCH_WB_BYPASS_EN
    checks++; if (id_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_wb_ready got %0h want 1", id_ready); end
    step();
    id_valid = 1'b0; wb_valid = 1'b0;
`else
    checks++; if (id_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_wb_ready got %0h want 0", id_ready); end
    step();
    wb_valid = 1'b0;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_late_ready got %0h want 1", id_ready); end
    step();
    id_valid = 1'b0;
`endif
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL raw_ex_valid got %0h want 1", ex_valid); end
    checks++; if (ex_rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL raw_rs1_data got %h want deadbeef", ex_rs1_data); end
    checks++; if (ex_rs2_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL raw_rs2_data got %h want deadbeef", ex_rs2_data); end
    checks++; if (ex_pc !== 32'h204) begin errors++; $display("[TB] FAIL raw_ex_pc got %h want 204", ex_pc); end
    checks++; if (dut.busy[6:5] !== 2'b10) begin errors++; $display("[TB] FAIL raw_busy65 got %b want 10", dut.busy[6:5]); end
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    step();
    wb_valid = 1'b0;
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("[TB] FAIL raw_busy_clear got %h want 0", dut.busy); end
  endtask

  // Backpressure: the held instruction stays stable, then the next one loads
  // with no bubble.
  task automatic test_backpressure();
    ex_ready = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd10; id_rd_we = 1'b0; id_pc = 32'h300;
    step();
    checks++; if (ex_rs1_data !== 32'h1000_0001) begin errors++; $display("[TB] FAIL bp_rs1 got %h want 10000001", ex_rs1_data); end
    checks++; if (ex_rs2_data !== 32'h1000_0002) begin errors++; $display("[TB] FAIL bp_rs2 got %h want 10000002", ex_rs2_data); end
    id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd11; id_pc = 32'h304;
    #1;
    checks++; if (rf_src_addr_1 !== 5'd3) begin errors++; $display("[TB] FAIL bp_addr1 got %0d want 3", rf_src_addr_1); end
    checks++; if (rf_src_addr_2 !== 5'd4) begin errors++; $display("[TB] FAIL bp_addr2 got %0d want 4", rf_src_addr_2); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (id_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_c%0d got %0h want 0", c, id_ready); end
      step();
      checks++; if (ex_pc !== 32'h300) begin errors++; $display("[TB] FAIL bp_hold_pc_c%0d got %h want 300", c, ex_pc); end
      checks++; if (ex_rs1_data !== 32'h1000_0001) begin errors++; $display("[TB] FAIL bp_hold_rs1_c%0d got %h want 10000001", c, ex_rs1_data); end
    end
    ex_ready = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %0h want 1", id_ready); end
    step();
    id_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_valid got %0h want 1", ex_valid); end
    checks++; if (ex_pc !== 32'h304) begin errors++; $display("[TB] FAIL bp_next_pc got %h want 304", ex_pc); end
    checks++; if (ex_rs2_data !== 32'h1000_0004) begin errors++; $display("[TB] FAIL bp_next_rs2 got %h want 10000004", ex_rs2_data); end
  endtask

  // WAW on rd=7: the accept and the writeback clear collide, and the set wins.
  task automatic test_waw();
    id_valid = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rd = 5'd7; id_rd_we = 1'b1; id_pc = 32'h400;
    step();
    checks++; if (dut.busy[7] !== 1'b1) begin errors++; $display("[TB] FAIL waw_busy7 got %0h want 1", dut.busy[7]); end
    id_pc = 32'h404;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("[TB] FAIL waw_stall got %0h want 0", id_ready); end
    step();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("[TB] FAIL waw_stall2 got %0h want 0", id_ready); end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("[TB] FAIL waw_release got %0h want 1", id_ready); end
    step();
    id_valid = 1'b0;
    checks++; if (dut.busy[7] !== 1'b1) begin errors++; $display("[TB] FAIL waw_collide_busy7 got %0h want 1", dut.busy[7]); end
    checks++; if (ex_pc !== 32'h404) begin errors++; $display("[TB] FAIL waw_ex_pc got %h want 404", ex_pc); end
    step();
    wb_valid = 1'b0;
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("[TB] FAIL waw_busy_clear got %h want 0", dut.busy); end
  endtask

  // Flush kills the held writer, releases its scoreboard bit and blocks
  // decode for that cycle.
  task automatic test_flush();
    ex_ready = 1'b0;
    id_valid = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rd = 5'd9; id_rd_we = 1'b1; id_pc = 32'h500;
    step();
    checks++; if (dut.busy[9] !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_busy9 got %0h want 1", dut.busy[9]); end
    checks++; if (ex_rd_we !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_rd_we got %0h want 1", ex_rd_we); end
    id_rd = 5'd12; id_pc = 32'h504; flush = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready got %0h want 0", id_ready); end
    step();
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_ex_valid got %0h want 0", ex_valid); end
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("[TB] FAIL flush_busy got %h want 0", dut.busy); end
  endtask

  // x0 handling:
  //   - A writeback to x0 poisons the model's x0 with 0x1234.
  //   - Reads of x0 must still be zero.
  //   - Writers of x0 are not tracked.
  //   - A writeback to x0 is never forwarded.
  task automatic test_x0();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    step();
    wb_valid = 1'b0;
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("[TB] FAIL x0_wb_busy got %h want 0", dut.busy); end
    id_valid = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd_we = 1'b1; id_pc = 32'h600;
    step();
    checks++; if (ex_rs1_data !== 32'h0) begin errors++; $display("[TB] FAIL x0_rs1 got %h want 0", ex_rs1_data); end
    checks++; if (ex_rd_we !== 1'b1) begin errors++; $display("[TB] FAIL x0_rd_we got %0h want 1", ex_rd_we); end
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("[TB] FAIL x0_issue_busy got %h want 0", dut.busy); end
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hABCD;
    id_rd_we = 1'b0; id_pc = 32'h604;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_fwd_ready got %0h want 1", id_ready); end
    step();
    idle();
    checks++; if (ex_rs1_data !== 32'h0) begin errors++; $display("[TB] FAIL x0_nofwd_rs1 got %h want 0", ex_rs1_data); end
    checks++; if (ex_rs2_data !== 32'h0) begin errors++; $display("[TB] FAIL x0_nofwd_rs2 got %h want 0", ex_rs2_data); end
    checks++; if (ex_pc !== 32'h604) begin errors++; $display("[TB] FAIL x0_ex_pc got %h want 604", ex_pc); end
  endtask

  // Run the scenarios in sequence, then print the summary.
  initial begin
    checks = 0;
    errors = 0;
    idle();
    test_reset();
    test_reset_midop();
    test_raw_bypass();
    test_backpressure();
    test_waw();
    test_flush();
    test_x0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
